// File: rtl/adder64_seq_ctrl.sv
// adder64_seq_ctrl: 64-bit add built from one SLICE_W-bit adder slice that is
// reused over 64/SLICE_W passes. The carry is held in a register between
// passes. Operands arrive on a valid/ready handshake and results leave on one.
// Optional feature macro: ADDER_SEQ_OVF_EN compiles in the signed-overflow
// flag. Without it, the ovf port is tied to 0.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice added per cycle, idx selects the slice
// DONE  | result held on sum/c_out/ovf with out_valid high
module adder64_seq_ctrl #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sum,
  output logic        c_out,
  output logic        busy,
  output logic        ovf
);

  localparam int P     = 64 / SLICE_W;
  localparam int IDX_W = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   slice_res;
  logic               last_pass;
`ifdef ADDER_SEQ_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Select the operand slices for the current pass. Constant part-selects
  // keep the mux free of variable-offset arithmetic.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < P; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  assign slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};
  assign last_pass = (idx_q == IDX_W'(P - 1));

  // Next-state and datapath update. Every register holds its value by default.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    c_out_d     = c_out_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
`ifdef ADDER_SEQ_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          sum_d   = '0;
          c_out_d = 1'b0;
`ifdef ADDER_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        carry_d = slice_res[SLICE_W];
        for (int i = 0; i < P; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*SLICE_W +: SLICE_W] = slice_res[SLICE_W-1:0];
          end
        end
        if (last_pass) begin
          // idx stays at P-1 so it never wraps.
          c_out_d     = slice_res[SLICE_W];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
`ifdef ADDER_SEQ_OVF_EN
          // On the last pass the slice MSB is bit 63 of the final sum.
          ovf_d = (a_q[63] == b_q[63]) && (slice_res[SLICE_W-1] != a_q[63]);
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers. Reset clears every visible output so that an aborted
  // operation leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef ADDER_SEQ_OVF_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule
